ntt_bram_seq: RTL and testbench

- Sequencer owning the shared 4096-deep x 64-bit coefficient BRAM port for one NTT pass.
- Streams NUM_WORDS input coefficients into BRAM, pulses the NTT core, waits for core completion, then reads NUM_WORDS results back out as a stream.
- Sits between the host-side coefficient stream and the BRAM/NTT core; the sole driver of the BRAM_* interface.

---
 rtl/ntt_bram_seq_if.sv | 36 +++
 rtl/ntt_bram_seq.sv | 128 ++++++++++++
 tb/tb_ntt_bram_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_bram_seq_if.sv
// Host, NTT-core and BRAM-port signals of the NTT pass sequencer.
// The sequencer takes the slave view; the environment takes the master view.
interface ntt_bram_seq_if;
   logic        start;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        core_start;
   logic        core_done;
   logic        out_valid;
   logic [63:0] out_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [11:0] BRAM_addr;
   logic        BRAM_clk;
   logic [63:0] BRAM_din;
   logic [63:0] BRAM_dout;
   logic        BRAM_en;
   logic        BRAM_rst;
   logic        BRAM_we;

   modport slave (
      input  start, in_valid, in_data, core_done, BRAM_dout,
      output in_ready, core_start, out_valid, out_data, busy, done,
      output error, BRAM_addr, BRAM_clk, BRAM_din, BRAM_en,
      output BRAM_rst, BRAM_we
   );

   modport master (
      output start, in_valid, in_data, core_done, BRAM_dout,
      input  in_ready, core_start, out_valid, out_data, busy, done,
      input  error, BRAM_addr, BRAM_clk, BRAM_din, BRAM_en,
      input  BRAM_rst, BRAM_we
   );
endinterface

// File: rtl/ntt_bram_seq.sv
// One NTT pass: load coefficients into BRAM, kick the core,
// wait for completion, then stream the results back out.
module ntt_bram_seq #(
   parameter int NUM_WORDS  = 64,
   parameter int BASE_ADDR  = 0,
   parameter int ADDR_SHIFT = 2,
   parameter int READ_LAT   = 1,
   parameter int TIMEOUT    = 65535
) (
   input logic          clk,
   input logic          rst,
   ntt_bram_seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_READ, S_FLUSH, S_DONE
   } state_t;

   localparam int CW = $clog2(NUM_WORDS + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST  = CW'(NUM_WORDS - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [READ_LAT-1:0] TAP = READ_LAT'(1) << (READ_LAT - 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [TW-1:0]       tcnt_q, tcnt_d;
   logic [READ_LAT-1:0] vld_q, vld_d;
   logic                err_q, err_d;
   logic                wr, rd;
   logic [11:0]         addr;

   assign addr = 12'((BASE_ADDR + int'(cnt_q)) << ADDR_SHIFT);

   assign bus.BRAM_clk = clk;
   assign bus.BRAM_rst = ~rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         vld_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      err_d   = err_q;
      vld_d   = (vld_q << 1) | READ_LAT'(rd);
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (bus.in_valid) begin
               if (cnt_q == LAST) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  tcnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_RUN: begin
            tcnt_d = tcnt_q + TW'(1);
            // core_done is blind during the core_start cycle
            if (tcnt_q != '0 && bus.core_done) begin
               state_d = S_READ;
            end else if (tcnt_q == TLAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         S_READ: begin
            if (cnt_q == LAST) state_d = S_FLUSH;
            else               cnt_d   = cnt_q + CW'(1);
         end
         S_FLUSH: begin
            // leave once only the beat on the output tap remains
            if ((vld_q & ~TAP) == '0) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr             = 1'b0;
      rd             = 1'b0;
      bus.in_ready   = 1'b0;
      bus.core_start = 1'b0;
      bus.done       = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            bus.in_ready = 1'b1;
            wr           = bus.in_valid;
         end
         S_RUN:   bus.core_start = (tcnt_q == '0);
         S_READ:  rd = 1'b1;
         S_DONE:  bus.done = 1'b1;
         default: ;
      endcase
      bus.BRAM_en   = wr | rd;
      bus.BRAM_we   = wr;
      bus.BRAM_addr = (wr | rd) ? addr : 12'd0;
      bus.BRAM_din  = wr ? bus.in_data : 64'd0;
      bus.out_valid = |(vld_q & TAP);
      bus.out_data  = bus.out_valid ? bus.BRAM_dout : 64'd0;
      bus.busy      = (state_q != S_IDLE);
      bus.error     = err_q;
   end

endmodule

// File: tb/tb_ntt_bram_seq.sv
// Scoreboard bench for ntt_bram_seq with a behavioural BRAM whose
// reads return stored word + 1, standing in for the NTT transform.
module tb_ntt_bram_seq;

   localparam int NW  = 64;
   localparam int BASE = 16;
   localparam int SH  = 2;
   localparam int LAT = 3;
   localparam int TO  = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ntt_bram_seq_if bus();

   ntt_bram_seq #(
      .NUM_WORDS(NW), .BASE_ADDR(BASE), .ADDR_SHIFT(SH),
      .READ_LAT(LAT), .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst_n),
      .bus(bus.slave)
   );

   // BRAM model: read data appears LAT cycles after the read request
   logic [63:0] mem [4096];
   logic [63:0] rpipe [LAT];

   always @(posedge clk) begin
      if (bus.BRAM_en && bus.BRAM_we) mem[bus.BRAM_addr] <= bus.BRAM_din;
      rpipe[0] <= (bus.BRAM_en && !bus.BRAM_we) ?
                  mem[bus.BRAM_addr] + 64'd1 : 64'hDEAD_BEEF_0000_0000;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign bus.BRAM_dout = rpipe[LAT-1];

   // scoreboard queues filled by the driver, drained by the monitor
   logic [11:0] wa_q[$];
   logic [63:0] wd_q[$];
   logic [11:0] ra_q[$];
   logic [63:0] out_q[$];
   int rd_cyc[$];
   int out_cyc[$];
   int cs_cyc[$];
   int dn_cyc[$];

   function automatic logic [11:0] word_addr(int k);
      return 12'(((BASE + k) * (1 << SH)) % 4096);
   endfunction

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)",
                  n, act, exp, cyc);
      end
   endtask

   task automatic fail_ev(string n);
      tests++;
      fails++;
      $display("FAIL %s: unexpected event at cycle %0d", n, cyc);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.BRAM_en && bus.BRAM_we) begin
            if (wa_q.size() == 0) fail_ev("extra_write");
            else begin
               chk("wr_addr", 64'(bus.BRAM_addr), 64'(wa_q.pop_front()));
               chk("wr_data", bus.BRAM_din, wd_q.pop_front());
            end
         end
         if (bus.BRAM_en && !bus.BRAM_we) begin
            rd_cyc.push_back(cyc);
            if (ra_q.size() == 0) fail_ev("extra_read");
            else chk("rd_addr", 64'(bus.BRAM_addr), 64'(ra_q.pop_front()));
         end
         if (bus.out_valid) begin
            out_cyc.push_back(cyc);
            if (out_q.size() == 0) fail_ev("extra_out");
            else chk("out_data", bus.out_data, out_q.pop_front());
         end
         if (bus.core_start) cs_cyc.push_back(cyc);
         if (bus.done) dn_cyc.push_back(cyc);
      end
   end

   task automatic check_reset_outputs(string n);
      chk({n, "_ctl"}, 64'({bus.in_ready, bus.core_start, bus.out_valid,
                            bus.busy, bus.done, bus.error,
                            bus.BRAM_en, bus.BRAM_we}), 64'd0);
      chk({n, "_addr"}, 64'(bus.BRAM_addr), 64'd0);
      chk({n, "_din"}, bus.BRAM_din, 64'd0);
      chk({n, "_dout"}, bus.out_data, 64'd0);
      chk({n, "_bram_rst"}, 64'(bus.BRAM_rst), 64'd1);
   endtask

   // gap: 0 back-to-back, 1 alternate idle cycle, 2 random gaps
   // cd_delay: cycles from core_start to core_done; 0 means never
   task automatic run_pass(input int gap, input int cd_delay,
                           input bit cd_early, input bit start_in_load,
                           input int rst_after);
      int t, n, rd0, out0, cs0, dn0;
      logic [63:0] d;
      rd0  = rd_cyc.size();
      out0 = out_cyc.size();
      cs0  = cs_cyc.size();
      dn0  = dn_cyc.size();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      chk("busy_on_start", 64'(bus.busy), 64'd1);
      chk("error_cleared", 64'(bus.error), 64'd0);
      bus.core_done = cd_early;
      for (int k = 0; k < NW; k++) begin
         if (gap == 1 || (gap == 2 && $urandom_range(1) == 1)) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
         end
         d = {$urandom, $urandom};
         chk("in_ready", 64'(bus.in_ready), 64'd1);
         bus.in_valid = 1'b1;
         bus.in_data  = d;
         wa_q.push_back(word_addr(k));
         wd_q.push_back(d);
         if (cd_delay > 0) begin
            ra_q.push_back(word_addr(k));
            out_q.push_back(d + 64'd1);
         end
         if (start_in_load && k == NW / 2) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk("core_start_after_load", 64'(bus.core_start), 64'd1);
      chk("writes_drained", 64'(wd_q.size()), 64'd0);
      t = cyc;
      for (int i = 1; i <= cd_delay; i++) begin
         @(posedge clk); #1;
         bus.core_done = (i == cd_delay);
      end
      @(posedge clk); #1 bus.core_done = 1'b0;
      n = 0;
      while (!bus.done && n < 2000) begin
         if (rst_after > 0 && rd_cyc.size() - rd0 >= rst_after) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("midpass_rst");
            @(posedge clk); #3 rst_n = 1'b1;
            wa_q.delete(); wd_q.delete(); ra_q.delete(); out_q.delete();
            for (int i = 0; i < 4; i++) begin
               @(posedge clk); #1;
               chk("post_rst_idle", 64'({bus.busy, bus.out_valid}), 64'd0);
            end
            return;
         end
         @(posedge clk); #1;
         n++;
      end
      if (!bus.done) begin
         fail_ev("done_timeout");
         return;
      end
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("idle_after_done", 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      chk("start_in_done_ignored", 64'(bus.busy), 64'd0);
      chk("core_start_count", 64'(cs_cyc.size() - cs0), 64'd1);
      chk("done_count", 64'(dn_cyc.size() - dn0), 64'd1);
      if (cd_delay > 0) begin
         chk("error_clear", 64'(bus.error), 64'd0);
         chk("read_count", 64'(rd_cyc.size() - rd0), 64'(NW));
         chk("out_count", 64'(out_cyc.size() - out0), 64'(NW));
         if (rd_cyc.size() - rd0 == NW && out_cyc.size() - out0 == NW) begin
            chk("first_read", 64'(rd_cyc[rd0]), 64'(t + cd_delay + 1));
            chk("reads_contig", 64'(rd_cyc[rd0+NW-1] - rd_cyc[rd0] + 1),
                64'(NW));
            chk("first_out_lat", 64'(out_cyc[out0] - rd_cyc[rd0]), 64'(LAT));
            chk("outs_contig", 64'(out_cyc[out0+NW-1] - out_cyc[out0] + 1),
                64'(NW));
            chk("flush_len", 64'(dn_cyc[dn0] - rd_cyc[rd0+NW-1] - 1),
                64'(LAT));
         end
         chk("outs_drained", 64'(out_q.size()), 64'd0);
      end else begin
         chk("timeout_error", 64'(bus.error), 64'd1);
         chk("timeout_no_reads", 64'(rd_cyc.size() - rd0), 64'd0);
         chk("timeout_cycle", 64'(dn_cyc[dn0]), 64'(t + TO));
      end
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 64'd0;
      bus.core_done = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset");
      chk("bram_clk", 64'(bus.BRAM_clk), 64'(clk));
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("bram_rst_release", 64'(bus.BRAM_rst), 64'd0);
      run_pass(0, 10, 1'b0, 1'b0, 0);
      run_pass(1, 5, 1'b1, 1'b1, 0);
      run_pass(0, 0, 1'b0, 1'b0, 0);
      run_pass(2, 17, 1'b0, 1'b0, 0);
      run_pass(0, 10, 1'b0, 1'b0, 20);
      run_pass(0, 10, 1'b0, 1'b0, 0);
      for (int p = 0; p < 4; p++) begin
         run_pass(2, int'($urandom_range(40, 1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
